stitch_pipeline_out_fifo: RTL and testbench

//  Downstream consumer of a stitched valid-only pipeline (no stall path).

---
 rtl/stitch_pipeline_out_fifo.sv | 93 +++++++++
 tb/tb_stitch_pipeline_out_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stitch_pipeline_out_fifo.sv
// Output buffer for a stall-free valid-only pipeline: FWFT FIFO plus credit
// counter so the pipeline never launches more items than the FIFO can absorb.
module stitch_pipeline_out_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           issue_error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         reserved;

  logic full;
  logic pop;
  logic push;
  logic issue_fire;
  logic credit_ret;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + PW'(1));
  endfunction

  // Head is visible straight from storage; no same-cycle bypass of in_data.
  assign out_valid   = (count != '0);
  assign out_data    = mem[rd_ptr];
  assign full        = (count == CW'(DEPTH));
  assign pop         = out_valid & out_ready;
  assign push        = in_valid & (~full | pop);
  assign issue_ready = (reserved < CW'(DEPTH));
  assign issue_fire  = issue_valid & issue_ready;
  // Never return a credit that was not taken, so reserved cannot wrap below zero.
  assign credit_ret  = pop & (reserved != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      reserved    <= '0;
      overflow    <= 1'b0;
      issue_error <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end

      case ({push, pop})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase

      case ({issue_fire, credit_ret})
        2'b10:   reserved <= CW'(reserved + CW'(1));
        2'b01:   reserved <= CW'(reserved - CW'(1));
        default: reserved <= reserved;
      endcase

      if (in_valid && full && !pop) begin
        overflow <= 1'b1;
      end
      if (issue_valid && !issue_ready) begin
        issue_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stitch_pipeline_out_fifo.sv
// Directed and scoreboarded checks of the pipeline output FIFO and its credit counter.
module tb_stitch_pipeline_out_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          issue_error;

  int n_total = 0;
  int n_bad   = 0;

  stitch_pipeline_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow),
    .issue_error (issue_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic          s0_v, s1_v;
  logic [DW-1:0] s0_d, s1_d;
  logic [DW-1:0] q[$];
  logic          quiet;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count", 64'(count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_issue_error", 64'(issue_error), 0);
    check("rst_issue_ready", 64'(issue_ready), 1);

    // single item, two-cycle pipeline latency
    issue_valid = 1'b1;
    next_cycle();
    issue_valid = 1'b0;
    check("t1_ready_after_issue", 64'(issue_ready), 1);
    next_cycle();
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    check("t1_no_bypass", 64'(out_valid), 0);
    next_cycle();
    in_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 1);
    check("t1_out_data", 64'(out_data), 64'hDEADBEEF);
    check("t1_count1", 64'(count), 1);
    next_cycle();
    out_ready = 1'b0;
    check("t1_count0", 64'(count), 0);
    check("t1_out_valid0", 64'(out_valid), 0);
    check("t1_ready_end", 64'(issue_ready), 1);

    // fill to DEPTH, then drain in order
    for (int i = 0; i < 4; i++) begin
      check("t2_ready_pre", 64'(issue_ready), 1);
      issue_valid = 1'b1;
      next_cycle();
    end
    issue_valid = 1'b0;
    check("t2_ready_full", 64'(issue_ready), 0);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    check("t2_count4", 64'(count), 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_drain_data", 64'(out_data), 64'(i));
      next_cycle();
      if (i == 1) check("t2_ready_after_pop", 64'(issue_ready), 1);
    end
    out_ready = 1'b0;
    check("t2_count_empty", 64'(count), 0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      next_cycle();
    end
    issue_valid = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      next_cycle();
    end
    in_valid = 1'b1; in_data = 32'd14; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count", 64'(count), 4);
    check("t3_head", 64'(out_data), 11);
    check("t3_no_overflow", 64'(overflow), 0);
    issue_valid = 1'b1;
    next_cycle();
    issue_valid = 1'b0;
    check("t3_ready_refull", 64'(issue_ready), 0);

    // full FIFO, push without pop is dropped
    in_valid = 1'b1; in_data = 32'h99;
    next_cycle();
    in_valid = 1'b0;
    check("t4_overflow", 64'(overflow), 1);
    check("t4_count", 64'(count), 4);
    check("t4_head", 64'(out_data), 11);
    repeat (10) next_cycle();
    check("t4_overflow_sticky", 64'(overflow), 1);

    // illegal issue, then issue+pop at reserved = DEPTH-1
    issue_valid = 1'b1;
    next_cycle();
    issue_valid = 1'b0;
    check("t5_issue_error", 64'(issue_error), 1);
    check("t5_ready_blocked", 64'(issue_ready), 0);
    out_ready = 1'b1;
    check("t5_pop_data", 64'(out_data), 11);
    next_cycle();
    out_ready = 1'b0;
    check("t5_reserved_unchanged", 64'(issue_ready), 1);
    check("t5_count3", 64'(count), 3);
    issue_valid = 1'b1; out_ready = 1'b1;
    check("t5_pop_data2", 64'(out_data), 12);
    next_cycle();
    issue_valid = 1'b0; out_ready = 1'b0;
    check("t5_ready_hold", 64'(issue_ready), 1);
    issue_valid = 1'b1;
    next_cycle();
    issue_valid = 1'b0;
    check("t5_ready_at_depth", 64'(issue_ready), 0);
    out_ready = 1'b1;
    check("t5_drain13", 64'(out_data), 13);
    next_cycle();
    check("t5_drain14", 64'(out_data), 14);
    next_cycle();
    out_ready = 1'b0;
    check("t5_empty", 64'(count), 0);
    check("t5_no_drop_data", 64'(out_valid), 0);

    // random credit-obeying run against a scoreboard
    rst = 1'b1;
    #2 rst = 1'b0;
    s0_v = 1'b0; s1_v = 1'b0; s0_d = '0; s1_d = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      next_cycle();
      in_valid = s1_v; in_data = s1_d;
      s1_v = s0_v; s1_d = s0_d;
      quiet = (cyc >= 9980);
      issue_valid = !quiet && issue_ready && ($urandom_range(0, 3) != 0);
      out_ready = quiet ? 1'b1 : 1'($urandom_range(0, 1));
      s0_v = issue_valid; s0_d = $urandom;
      #1;
      check("t6_out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && out_ready && q.size() != 0) begin
        check("t6_out_data", 64'(out_data), 64'(q.pop_front()));
      end
      if (in_valid) q.push_back(in_data);
    end
    next_cycle();
    in_valid = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
    check("t6_count_end", 64'(count), 0);
    check("t6_no_overflow", 64'(overflow), 0);
    check("t6_no_issue_error", 64'(issue_error), 0);

    // build up state and sticky flags, then reset asynchronously mid-cycle
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; in_valid = 1'b1; in_data = DW'(32'hA0 + i);
      next_cycle();
    end
    issue_valid = 1'b0; in_valid = 1'b0;
    check("t6_pre_count", 64'(count), 4);
    check("t6_pre_overflow", 64'(overflow), 1);
    check("t6_pre_issue_error", 64'(issue_error), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_arst_count", 64'(count), 0);
    check("t6_arst_out_valid", 64'(out_valid), 0);
    check("t6_arst_overflow", 64'(overflow), 0);
    check("t6_arst_issue_error", 64'(issue_error), 0);
    check("t6_arst_issue_ready", 64'(issue_ready), 1);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h55;
    next_cycle();
    in_valid = 1'b0;
    check("t6_post_rst_push", 64'(count), 1);
    check("t6_post_rst_data", 64'(out_data), 64'h55);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
